// File: rtl/parameters.sv
// parameters -- definitions shared by the configuration datapath.
// Holds the size of the configuration register file and the state
// encoding of the conf_loader write sequencer.
package parameters;

  // Number of registers in the configuration register file.
  localparam int unsigned CONF_REGISTERS_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_IDX,
    RD_DAT,
    WRITE
  } conf_loader_state_t;

endpackage : parameters

// File: rtl/conf_loader.sv
// conf_loader -- configuration write sequencer.
// Walks a table of (register index, data) word pairs in config memory and
// replays each pair as a one-cycle write on the register-file port.
// Optional feature: define CONF_LOADER_RANGE_CHECK_EN to drop writes whose
// register index is outside the register file and flag them on err_addr.
module conf_loader
  import parameters::*;
#(
  parameter int MEM_ADDR_W    = 16,
  parameter int MAX_RECORDS_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MEM_ADDR_W-1:0]    base_addr,
  input  logic [MAX_RECORDS_W-1:0] num_records,
  output logic                     mem_rd_en,
  output logic [MEM_ADDR_W-1:0]    mem_rd_addr,
  input  logic [31:0]              mem_rd_data,
  output logic                     wr_en_ext,
  output logic [31:0]              wr_addr_ext,
  output logic [31:0]              wr_data_ext,
  output logic                     busy,
  output logic                     done,
  output logic                     err_addr
);

  conf_loader_state_t       state_q, state_d;
  logic [MEM_ADDR_W-1:0]    ptr_q, ptr_d;
  logic [MAX_RECORDS_W-1:0] remaining_q, remaining_d;
  logic [31:0]              idx_q, idx_d;
  logic                     wr_en_q, wr_en_d;
  logic [31:0]              wr_addr_q, wr_addr_d;
  logic [31:0]              wr_data_q, wr_data_d;
  logic                     done_q, done_d;
  logic                     wr_ok;

`ifdef CONF_LOADER_RANGE_CHECK_EN
  logic err_q, err_d;

  // Only indices that land inside the register file may be written.
  assign wr_ok    = (idx_q < 32'(CONF_REGISTERS_SIZE));
  assign err_addr = err_q;
`else
  assign wr_ok    = 1'b1;
  assign err_addr = 1'b0;
`endif

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
`ifdef CONF_LOADER_RANGE_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_records != '0) begin
            ptr_d       = base_addr;
            remaining_d = num_records;
            state_d     = RD_IDX;
`ifdef CONF_LOADER_RANGE_CHECK_EN
            err_d       = 1'b0;
`endif
          end else begin
            // Empty table: acknowledge immediately, touch nothing.
            done_d = 1'b1;
          end
        end
      end

      RD_IDX: state_d = RD_DAT;

      RD_DAT: begin
        // Index word requested in RD_IDX is on the read bus now.
        idx_d   = mem_rd_data;
        state_d = WRITE;
      end

      WRITE: begin
        // Data word requested in RD_DAT is on the read bus now.
        if (wr_ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = mem_rd_data;
        end
`ifdef CONF_LOADER_RANGE_CHECK_EN
        else begin
          err_d = 1'b1;
        end
`endif
        ptr_d       = ptr_q + MEM_ADDR_W'(2);
        remaining_d = remaining_q - MAX_RECORDS_W'(1);
        if (remaining_q == MAX_RECORDS_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_IDX;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
`ifdef CONF_LOADER_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
`ifdef CONF_LOADER_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Memory read port is decoded directly from the current state; the
  // address sits at zero whenever no read is issued.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    if (state_q == RD_IDX) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = ptr_q;
    end else if (state_q == RD_DAT) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = ptr_q + MEM_ADDR_W'(1);
    end
  end

  assign wr_en_ext   = wr_en_q;
  assign wr_addr_ext = wr_addr_q;
  assign wr_data_ext = wr_data_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule : conf_loader

// File: tb/tb_conf_loader.sv
// tb_conf_loader -- directed, table-driven bench for conf_loader.
// Cycle 0 is the cycle in which start is high; outputs are sampled on the
// falling edge of each cycle. Build with CONF_LOADER_RANGE_CHECK_EN defined
// to exercise the range-check variant.
module tb_conf_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_records;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        wr_en_ext;
  logic [31:0] wr_addr_ext;
  logic [31:0] wr_data_ext;
  logic        busy;
  logic        done;
  logic        err_addr;

  conf_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_records (num_records),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .wr_en_ext   (wr_en_ext),
    .wr_addr_ext (wr_addr_ext),
    .wr_data_ext (wr_data_ext),
    .busy        (busy),
    .done        (done),
    .err_addr    (err_addr)
  );

  always #5 clk = ~clk;

  // Config memory: synchronous read, data valid the cycle after the request.
  logic [31:0] mem [0:65535];
  initial mem_rd_data = '0;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_ev_t;

  wr_ev_t      wq[$];
  logic [15:0] rq[$];
  int          done_cnt;
  int          done_cyc;
  logic        busy_at_done;
  logic        busy_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    wq.delete();
    rq.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    busy_at_done = 1'b0;
    busy_seen    = 1'b0;
  endtask

  task automatic sample(input int c);
    if (wr_en_ext) wq.push_back('{c, wr_addr_ext, wr_data_ext});
    if (mem_rd_en) rq.push_back(mem_rd_addr);
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) begin
        done_cyc     = c;
        busy_at_done = busy;
      end
    end
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic run_table(input logic [15:0] b, input logic [15:0] n, input int ncyc);
    clear_obs();
    @(negedge clk);
    base_addr   = b;
    num_records = n;
    start       = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      sample(c);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " mem_rd_en"},   32'(mem_rd_en),   32'h0);
    check({tag, " mem_rd_addr"}, 32'(mem_rd_addr), 32'h0);
    check({tag, " wr_en_ext"},   32'(wr_en_ext),   32'h0);
    check({tag, " wr_addr_ext"}, wr_addr_ext,      32'h0);
    check({tag, " wr_data_ext"}, wr_data_ext,      32'h0);
    check({tag, " busy"},        32'(busy),        32'h0);
    check({tag, " done"},        32'(done),        32'h0);
    check({tag, " err_addr"},    32'(err_addr),    32'h0);
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] num;
    int          exp_writes;
    int          exp_done;
    logic [31:0] exp_addr;   // wr_addr_ext after the run (holds last write)
    logic [31:0] exp_data;
    int          exp_reads;
  } vec_t;

  initial begin
    vec_t vecs[4];
    vecs[0] = '{16'h0010, 16'd1, 1, 4,  32'd2, 32'hDEADBEEF, 2};
    vecs[1] = '{16'h0000, 16'd3, 3, 10, 32'd7, 32'hC0C0_0003, 6};
    vecs[2] = '{16'h0000, 16'd0, 0, 1,  32'd7, 32'hC0C0_0003, 0};
    vecs[3] = '{16'hFFFE, 16'd2, 2, 7,  32'd5, 32'hA0A0_0001, 4};

    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0010] = 32'd2;  mem[16'h0011] = 32'hDEADBEEF;
    mem[16'h0000] = 32'd5;  mem[16'h0001] = 32'hA0A0_0001;
    mem[16'h0002] = 32'd6;  mem[16'h0003] = 32'hB0B0_0002;
    mem[16'h0004] = 32'd7;  mem[16'h0005] = 32'hC0C0_0003;
    mem[16'hFFFE] = 32'd9;  mem[16'hFFFF] = 32'h1111_2222;
    mem[16'h0100] = 32'd3;  mem[16'h0101] = 32'h0000_0033;
    mem[16'h0102] = 32'(parameters::CONF_REGISTERS_SIZE);
    mem[16'h0103] = 32'h0000_0044;
    mem[16'h0104] = 32'd4;  mem[16'h0105] = 32'h0000_0055;

    start = 1'b0; base_addr = '0; num_records = '0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Table-driven runs.
    for (int v = 0; v < 4; v++) begin
      run_table(vecs[v].base, vecs[v].num, 3 * int'(vecs[v].num) + 6);
      check($sformatf("v%0d n_writes", v), 32'(wq.size()), 32'(vecs[v].exp_writes));
      check($sformatf("v%0d done_cyc", v), 32'(done_cyc), 32'(vecs[v].exp_done));
      check($sformatf("v%0d done_cnt", v), 32'(done_cnt), 32'd1);
      check($sformatf("v%0d busy_at_done", v), 32'(busy_at_done), 32'h0);
      check($sformatf("v%0d busy_seen", v), 32'(busy_seen), 32'(vecs[v].num != 0));
      check($sformatf("v%0d n_reads", v), 32'(rq.size()), 32'(vecs[v].exp_reads));
      check($sformatf("v%0d wr_addr_ext", v), wr_addr_ext, vecs[v].exp_addr);
      check($sformatf("v%0d wr_data_ext", v), wr_data_ext, vecs[v].exp_data);
      foreach (wq[k])
        check($sformatf("v%0d write%0d cyc", v, k), 32'(wq[k].cyc), 32'(4 + 3 * k));
    end

    // Read address order for a three-record table.
    run_table(16'h0000, 16'd3, 15);
    check("seq rd count", 32'(rq.size()), 32'd6);
    for (int k = 0; k < 6 && k < rq.size(); k++)
      check($sformatf("seq rd%0d", k), 32'(rq[k]), 32'(k));
    check("seq w1 addr", wq.size() > 1 ? wq[1].addr : 32'hFFFF_FFFF, 32'd6);
    check("seq w1 data", wq.size() > 1 ? wq[1].data : 32'hFFFF_FFFF, 32'hB0B0_0002);

    // Address wrap past the top of the config memory.
    run_table(16'hFFFE, 16'd2, 12);
    check("wrap rd count", 32'(rq.size()), 32'd4);
    if (rq.size() == 4) begin
      check("wrap rd0", 32'(rq[0]), 32'hFFFE);
      check("wrap rd1", 32'(rq[1]), 32'hFFFF);
      check("wrap rd2", 32'(rq[2]), 32'h0000);
      check("wrap rd3", 32'(rq[3]), 32'h0001);
    end
    check("wrap w0 addr", wq.size() > 0 ? wq[0].addr : 32'hFFFF_FFFF, 32'd9);
    check("wrap w0 data", wq.size() > 0 ? wq[0].data : 32'hFFFF_FFFF, 32'h1111_2222);

    // New start in the done cycle of the previous table is accepted.
    clear_obs();
    @(negedge clk);
    base_addr = 16'h0010; num_records = 16'd1; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      sample(c);
      start = (c == 4);
    end
    check("b2b n_writes", 32'(wq.size()), 32'd2);
    check("b2b done_cnt", 32'(done_cnt), 32'd2);
    check("b2b w1 cyc", wq.size() > 1 ? 32'(wq[1].cyc) : 32'hFFFF_FFFF, 32'd8);

    // Start while busy is ignored; reset in RD_DAT of record 1 abandons table.
    clear_obs();
    @(negedge clk);
    base_addr = 16'h0000; num_records = 16'd3; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      sample(c);
      start = 1'b0;
      if (c == 2) begin
        base_addr = 16'h0010; num_records = 16'd1; start = 1'b1;
      end
      if (c == 5) reset = 1'b1;
      if (c == 6) begin
        check_outputs_zero("after_reset");
        reset = 1'b0;
      end
    end
    check("rst n_writes", 32'(wq.size()), 32'd1);
    check("rst w0 addr", wq.size() > 0 ? wq[0].addr : 32'hFFFF_FFFF, 32'd5);
    check("rst n_reads", 32'(rq.size()), 32'd4);
    check("rst rd1", rq.size() > 1 ? 32'(rq[1]) : 32'hFFFF_FFFF, 32'd1);
    check("rst done_cnt", 32'(done_cnt), 32'd0);
    check("rst busy idle", 32'(busy), 32'h0);

    // Index equal to the register-file size.
    run_table(16'h0100, 16'd3, 15);
`ifdef CONF_LOADER_RANGE_CHECK_EN
    check("rng n_writes", 32'(wq.size()), 32'd2);
    check("rng w1 addr", wq.size() > 1 ? wq[1].addr : 32'hFFFF_FFFF, 32'd4);
    check("rng w1 cyc", wq.size() > 1 ? 32'(wq[1].cyc) : 32'hFFFF_FFFF, 32'd10);
    check("rng err_addr", 32'(err_addr), 32'h1);
`else
    check("rng n_writes", 32'(wq.size()), 32'd3);
    check("rng w1 addr", wq.size() > 1 ? wq[1].addr : 32'hFFFF_FFFF, 32'd32);
    check("rng w1 data", wq.size() > 1 ? wq[1].data : 32'hFFFF_FFFF, 32'h0000_0044);
    check("rng err_addr", 32'(err_addr), 32'h0);
`endif
    check("rng done_cyc", 32'(done_cyc), 32'd10);

    // Next accepted start clears the error flag.
    run_table(16'h0010, 16'd1, 8);
    check("clr err_addr", 32'(err_addr), 32'h0);
    check("clr w0 addr", wq.size() > 0 ? wq[0].addr : 32'hFFFF_FFFF, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_conf_loader
